// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: shares one RAM between CPU and DMA requesters with round-robin
// tie-break, a burst limit under contention, and registered per-port read data.
module ram_bus_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    output logic                  cpu_gnt_o,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                  cpu_rvalid_o,
    output logic                  cpu_stall_o,
    input  logic                  dma_req_i,
    input  logic                  dma_we_i,
    input  logic [ADDR_WIDTH-1:0] dma_addr_i,
    input  logic [DATA_WIDTH-1:0] dma_wdata_i,
    output logic                  dma_gnt_o,
    output logic [DATA_WIDTH-1:0] dma_rdata_o,
    output logic                  dma_rvalid_o,
    output logic                  mem_cs_o,
    output logic                  mem_oe_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, CPU_OWN, DMA_OWN} state_e;
    localparam int BW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    state_e          state_q, state_d;
    logic            last_dma_q, last_dma_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic            cpu_rvalid_q, dma_rvalid_q;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, dma_rdata_q;
    logic            cpu_acc, dma_acc, own_req, oth_req, keep;

    assign cpu_gnt_o = state_q == CPU_OWN;
    assign dma_gnt_o = state_q == DMA_OWN;
    assign cpu_acc   = cpu_gnt_o & cpu_req_i;
    assign dma_acc   = dma_gnt_o & dma_req_i;
    assign own_req   = cpu_gnt_o ? cpu_req_i : dma_req_i;
    assign oth_req   = cpu_gnt_o ? dma_req_i : cpu_req_i;
    // the burst limit only matters while the other side is waiting
    assign keep      = own_req & (~oth_req | (burst_q < BURST_LAST));

    always_comb begin
        state_d    = state_q;
        last_dma_d = last_dma_q;
        burst_d    = '0;
        if (state_q == IDLE) begin
            state_d = (cpu_req_i & (~dma_req_i | last_dma_q)) ? CPU_OWN :
                      dma_req_i ? DMA_OWN : IDLE;
        end else if (keep) begin
            burst_d = (burst_q == BURST_LAST) ? burst_q : burst_q + BW'(1);
        end else begin
            last_dma_d = dma_gnt_o;
            state_d    = oth_req ? (cpu_gnt_o ? DMA_OWN : CPU_OWN) : IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_dma_q   <= 1'b1;
            burst_q      <= '0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_dma_q   <= last_dma_d;
            burst_q      <= burst_d;
            cpu_rvalid_q <= cpu_acc & ~cpu_we_i;
            dma_rvalid_q <= dma_acc & ~dma_we_i;
            if (cpu_acc & ~cpu_we_i) cpu_rdata_q <= mem_rdata_i;
            if (dma_acc & ~dma_we_i) dma_rdata_q <= mem_rdata_i;
        end
    end

    assign cpu_rvalid_o = cpu_rvalid_q;
    assign dma_rvalid_o = dma_rvalid_q;
    assign cpu_rdata_o  = cpu_rdata_q;
    assign dma_rdata_o  = dma_rdata_q;
    assign cpu_stall_o  = cpu_req_i & ~cpu_gnt_o;
    assign mem_cs_o     = cpu_acc | dma_acc;
    assign mem_we_o     = cpu_acc ? cpu_we_i : dma_acc & dma_we_i;
    assign mem_oe_o     = mem_cs_o & ~mem_we_o;
    assign mem_addr_o   = cpu_acc ? cpu_addr_i : dma_acc ? dma_addr_i : '0;
    assign mem_wdata_o  = cpu_acc ? cpu_wdata_i : dma_acc ? dma_wdata_i : '0;
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb_ram_bus_arbiter: directed vectors plus randomized traffic checked against an
// ownership/access-count reference model, for MAX_BURST=4 and MAX_BURST=1 instances.
module tb_ram_bus_arbiter;
    logic clk = 1'b0;
    logic rst_n, preload;
    logic cpu_req, cpu_we, dma_req, dma_we;
    logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [1:0] cpu_gnt, cpu_rvalid, cpu_stall, dma_gnt, dma_rvalid, mem_cs, mem_oe, mem_we;
    logic [7:0] cpu_rdata [2];
    logic [7:0] dma_rdata [2];
    logic [7:0] mem_addr [2];
    logic [7:0] mem_wdata [2];
    logic [7:0] mem_rdata [2];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(int a);
        return a == 16 ? 8'hA5 : 8'(a + 48);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        logic [7:0] ram [256];
        ram_bus_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_BURST(g == 0 ? 4 : 1)) dut (
            .clk_i(clk), .rst_ni(rst_n),
            .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
            .cpu_gnt_o(cpu_gnt[g]), .cpu_rdata_o(cpu_rdata[g]), .cpu_rvalid_o(cpu_rvalid[g]),
            .cpu_stall_o(cpu_stall[g]),
            .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
            .dma_gnt_o(dma_gnt[g]), .dma_rdata_o(dma_rdata[g]), .dma_rvalid_o(dma_rvalid[g]),
            .mem_cs_o(mem_cs[g]), .mem_oe_o(mem_oe[g]), .mem_we_o(mem_we[g]),
            .mem_addr_o(mem_addr[g]), .mem_wdata_o(mem_wdata[g]), .mem_rdata_i(mem_rdata[g]));
        assign mem_rdata[g] = ram[mem_addr[g]];
        always @(posedge clk) begin
            if (preload) for (int a = 0; a < 256; a++) ram[a] <= init_val(a);
            else if (mem_cs[g] && mem_we[g]) ram[mem_addr[g]] <= mem_wdata[g];
        end
    end

    // reference: owner 0=none 1=cpu 2=dma, accesses used since taking the bus
    int m_own [2], m_used [2], m_last [2];
    int mb [2] = '{4, 1};
    logic m_crv [2], m_drv [2];
    logic [7:0] m_crd [2], m_drd [2];
    logic [7:0] ref_mem [2][256];
    logic s_cgnt, s_dgnt, s_cs, s_oe, s_stall, s_crv, s_drv;
    logic [7:0] s_addr, s_crd, s_drd;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_own[i] = 0; m_used[i] = 0; m_last[i] = 2;
            m_crv[i] = 0; m_drv[i] = 0; m_crd[i] = 0; m_drd[i] = 0;
        end
    endtask

    task automatic check_inst(int i);
        logic ca, da, ewe, ecs;
        logic [7:0] ea, ed;
        ca  = m_own[i] == 1 && cpu_req;
        da  = m_own[i] == 2 && dma_req;
        ecs = ca | da;
        ewe = ca ? cpu_we : (da & dma_we);
        ea  = ca ? cpu_addr : da ? dma_addr : 8'h00;
        ed  = ca ? cpu_wdata : da ? dma_wdata : 8'h00;
        chk($sformatf("i%0d_cpu_gnt", i), cpu_gnt[i], m_own[i] == 1);
        chk($sformatf("i%0d_dma_gnt", i), dma_gnt[i], m_own[i] == 2);
        chk($sformatf("i%0d_gnt_excl", i), cpu_gnt[i] & dma_gnt[i], 0);
        chk($sformatf("i%0d_stall", i), cpu_stall[i], cpu_req && m_own[i] != 1);
        chk($sformatf("i%0d_mem_cs", i), mem_cs[i], ecs);
        chk($sformatf("i%0d_mem_we", i), mem_we[i], ewe);
        chk($sformatf("i%0d_mem_oe", i), mem_oe[i], ecs & ~ewe);
        chk($sformatf("i%0d_mem_addr", i), mem_addr[i], ea);
        chk($sformatf("i%0d_mem_wdata", i), mem_wdata[i], ed);
        chk($sformatf("i%0d_cpu_rvalid", i), cpu_rvalid[i], m_crv[i]);
        chk($sformatf("i%0d_dma_rvalid", i), dma_rvalid[i], m_drv[i]);
        chk($sformatf("i%0d_cpu_rdata", i), cpu_rdata[i], m_crd[i]);
        chk($sformatf("i%0d_dma_rdata", i), dma_rdata[i], m_drd[i]);
    endtask

    task automatic model_step(int i);
        logic ca, da, xr, yr;
        ca = m_own[i] == 1 && cpu_req;
        da = m_own[i] == 2 && dma_req;
        m_crv[i] = ca && !cpu_we;
        m_drv[i] = da && !dma_we;
        if (m_crv[i]) m_crd[i] = ref_mem[i][cpu_addr];
        if (m_drv[i]) m_drd[i] = ref_mem[i][dma_addr];
        if (ca && cpu_we) ref_mem[i][cpu_addr] = cpu_wdata;
        if (da && dma_we) ref_mem[i][dma_addr] = dma_wdata;
        if (m_own[i] == 0) begin
            m_used[i] = 0;
            if (cpu_req && dma_req) m_own[i] = m_last[i] == 1 ? 2 : 1;
            else if (cpu_req) m_own[i] = 1;
            else if (dma_req) m_own[i] = 2;
        end else begin
            xr = m_own[i] == 1 ? cpu_req : dma_req;
            yr = m_own[i] == 1 ? dma_req : cpu_req;
            if (xr && (!yr || m_used[i] + 1 < mb[i])) m_used[i]++;
            else begin
                m_last[i] = m_own[i];
                m_own[i]  = yr ? 3 - m_own[i] : 0;
                m_used[i] = 0;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (!rst_n) model_reset();
        for (int i = 0; i < 2; i++) check_inst(i);
        s_cgnt = cpu_gnt[0]; s_dgnt = dma_gnt[0]; s_cs = mem_cs[0]; s_oe = mem_oe[0];
        s_stall = cpu_stall[0]; s_crv = cpu_rvalid[0]; s_drv = dma_rvalid[0];
        s_addr = mem_addr[0]; s_crd = cpu_rdata[0]; s_drd = dma_rdata[0];
        @(posedge clk);
        if (rst_n) for (int i = 0; i < 2; i++) model_step(i);
        #1;
    endtask

    typedef struct {
        logic rst_n, creq, dreq;
        logic cgnt, dgnt, cs, oe, stall, crv, drv;
        logic [7:0] addr, crd, drd;
    } vec_t;
    vec_t tv [16];

    initial begin
        int n, first, last_t;
        tv[0]  = '{0, 1, 0,  0, 0, 0, 0, 1, 0, 0,  8'h00, 8'h00, 8'h00};
        tv[1]  = '{1, 1, 0,  0, 0, 0, 0, 1, 0, 0,  8'h00, 8'h00, 8'h00};
        tv[2]  = '{1, 1, 0,  1, 0, 1, 1, 0, 0, 0,  8'h10, 8'h00, 8'h00};
        tv[3]  = '{1, 0, 0,  1, 0, 0, 0, 0, 1, 0,  8'h00, 8'hA5, 8'h00};
        tv[4]  = '{1, 0, 0,  0, 0, 0, 0, 0, 0, 0,  8'h00, 8'hA5, 8'h00};
        tv[5]  = '{0, 1, 1,  0, 0, 0, 0, 1, 0, 0,  8'h00, 8'h00, 8'h00};
        tv[6]  = '{1, 1, 1,  0, 0, 0, 0, 1, 0, 0,  8'h00, 8'h00, 8'h00};
        tv[7]  = '{1, 1, 1,  1, 0, 1, 1, 0, 0, 0,  8'h10, 8'h00, 8'h00};
        tv[8]  = '{1, 1, 1,  1, 0, 1, 1, 0, 1, 0,  8'h10, 8'hA5, 8'h00};
        tv[9]  = tv[8];
        tv[10] = tv[8];
        tv[11] = '{1, 1, 1,  0, 1, 1, 1, 1, 1, 0,  8'h40, 8'hA5, 8'h00};
        tv[12] = '{1, 1, 1,  0, 1, 1, 1, 1, 0, 1,  8'h40, 8'hA5, 8'h70};
        tv[13] = tv[12];
        tv[14] = tv[12];
        tv[15] = '{1, 1, 1,  1, 0, 1, 1, 0, 0, 1,  8'h10, 8'hA5, 8'h70};
        rst_n = 0; preload = 1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 8'h10; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 8'h40; dma_wdata = 0;
        @(posedge clk); #1;
        preload = 0;
        for (int i = 0; i < 2; i++) for (int a = 0; a < 256; a++) ref_mem[i][a] = init_val(a);
        model_reset();

        for (int r = 0; r < 16; r++) begin
            rst_n = tv[r].rst_n; cpu_req = tv[r].creq; dma_req = tv[r].dreq;
            cycle();
            chk($sformatf("tv%0d_cgnt", r), s_cgnt, tv[r].cgnt);
            chk($sformatf("tv%0d_dgnt", r), s_dgnt, tv[r].dgnt);
            chk($sformatf("tv%0d_cs", r), s_cs, tv[r].cs);
            chk($sformatf("tv%0d_oe", r), s_oe, tv[r].oe);
            chk($sformatf("tv%0d_stall", r), s_stall, tv[r].stall);
            chk($sformatf("tv%0d_crv", r), s_crv, tv[r].crv);
            chk($sformatf("tv%0d_drv", r), s_drv, tv[r].drv);
            chk($sformatf("tv%0d_addr", r), s_addr, tv[r].addr);
            chk($sformatf("tv%0d_crd", r), s_crd, tv[r].crd);
            chk($sformatf("tv%0d_drd", r), s_drd, tv[r].drd);
        end

        for (int t = 0; t < 600; t++) begin
            cpu_req = $urandom_range(0, 3) != 0; cpu_we = $urandom_range(0, 1) == 1;
            cpu_addr = 8'($urandom); cpu_wdata = 8'($urandom);
            dma_req = $urandom_range(0, 3) != 0; dma_we = $urandom_range(0, 1) == 1;
            dma_addr = 8'($urandom); dma_wdata = 8'($urandom);
            cycle();
        end

        cpu_req = 0; dma_req = 0;
        cycle(); cycle();
        dma_req = 1; dma_we = 1; dma_addr = 8'h20; dma_wdata = 8'hC0;
        n = 0; first = -1; last_t = -1;
        for (int t = 0; t < 40 && n < 10; t++) begin
            cycle();
            if (s_dgnt && dma_req) begin
                if (first < 0) first = t;
                n++;
                if (n == 10) begin dma_req = 0; last_t = t; end
                else begin dma_addr++; dma_wdata++; end
            end
        end
        chk("burst_count", n, 10);
        chk("burst_span", last_t - first + 1, 10);
        cycle(); cycle();
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("burst_ram0_%0d", k), gi[0].ram[8'h20 + k], 8'hC0 + k);
            chk($sformatf("burst_ram1_%0d", k), gi[1].ram[8'h20 + k], 8'hC0 + k);
        end

        dma_we = 0; dma_addr = 8'h50; dma_req = 1;
        n = 0;
        for (int t = 0; t < 10 && n == 0; t++) begin
            cycle();
            if (s_dgnt) n = 1;
        end
        chk("rst_dma_granted", n, 1);
        #2 rst_n = 0;
        #1;
        chk("rst_async_dgnt", dma_gnt[0], 0);
        chk("rst_async_cs", mem_cs[0], 0);
        chk("rst_async_drv", dma_rvalid[0], 0);
        chk("rst_async_drd", dma_rdata[0], 0);
        cycle();
        chk("rst_no_drv", s_drv, 0);
        rst_n = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 8'h30;
        cycle();
        chk("rst_idle_gnt", {s_cgnt, s_dgnt}, 2'b00);
        cycle();
        chk("rst_cpu_first", {s_cgnt, s_dgnt}, 2'b10);
        cycle();
        cpu_req = 0;
        cycle();
        chk("drop_cgnt_held", s_cgnt, 1);
        cycle();
        chk("drop_handover", {s_cgnt, s_dgnt}, 2'b01);
        dma_req = 0;
        cycle(); cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
